spi_apb_master: RTL

- APB3 initiator that turns single-entry commands into APB register accesses for the CoreSPI register file (control, status, CLK_DIV, SSEL and data registers).
- Supports write, read and hardware poll. Poll repeatedly reads one register until a masked value matches, so firmware or a test sequencer does not spin on the STATUS bits itself.
- Sits between the sequencer/CPU-side logic and the CoreSPI APB port.

---
 rtl/spi_apb_pkg.sv | 38 +++
 rtl/spi_apb_master_if.sv | 40 ++++
 rtl/apb_wait_timer.sv | 28 ++
 rtl/spi_apb_master.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/spi_apb_pkg.sv
// Shared types for the CoreSPI APB initiator: op codes, response codes,
// FSM states and the CoreSPI register map.
package spi_apb_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_SLVERR  = 2'b01,
    RSP_POLL_TO = 2'b10,
    RSP_WAIT_TO = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_GAP
  } state_e;

  localparam logic [6:0] REG_CTRL1   = 7'h00;
  localparam logic [6:0] REG_INTCLR  = 7'h04;
  localparam logic [6:0] REG_RXDATA  = 7'h08;
  localparam logic [6:0] REG_TXDATA  = 7'h0C;
  localparam logic [6:0] REG_INTMASK = 7'h10;
  localparam logic [6:0] REG_INTRAW  = 7'h14;
  localparam logic [6:0] REG_CTRL2   = 7'h18;
  localparam logic [6:0] REG_CMD     = 7'h1C;
  localparam logic [6:0] REG_STATUS  = 7'h20;
  localparam logic [6:0] REG_SSEL    = 7'h24;
  localparam logic [6:0] REG_CLKDIV  = 7'h2C;

endpackage

// File: rtl/spi_apb_master_if.sv
// Command/response handshake plus APB3 bus of the CoreSPI initiator.
// The master modport is the initiator's view; slave is the environment's view.
interface spi_apb_master_if #(
  parameter int DW = 8
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [6:0]    cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] cmd_mask;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;
  logic          busy;
  logic [6:0]    paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status, busy,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, busy,
    input  paddr, psel, penable, pwrite, pwdata
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Loadable down-counter that saturates at zero; used for poll gaps and
// for bounding how long the initiator waits on pready.
module apb_wait_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/spi_apb_master.sv
// APB3 initiator for CoreSPI: single-entry write/read/poll commands become
// APB transfers, with a one-cycle response pulse per command.
module spi_apb_master
  import spi_apb_pkg::*;
#(
  parameter int APB_DWIDTH = 8,
  parameter int POLL_LIMIT = 255,
  parameter int POLL_GAP   = 2,
  parameter int WAIT_LIMIT = 16
) (
  input logic               pclk,
  input logic               sreset,
  spi_apb_master_if.master  bus
);

  // Timers count down from limit-1 so that zero marks the last allowed cycle.
  localparam logic [7:0]  WAIT_LOAD = 8'(WAIT_LIMIT - 1);
  localparam logic [3:0]  GAP_LOAD  = 4'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);
  localparam logic [16:0] POLL_MAX  = 17'(POLL_LIMIT);

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [APB_DWIDTH-1:0]   wdata_q, wdata_d;
  logic [APB_DWIDTH-1:0]   mask_q, mask_d;
  logic [6:0]              paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [APB_DWIDTH-1:0]   pwdata_q, pwdata_d;
  logic [15:0]             poll_cnt_q, poll_cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [APB_DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_status_q, rsp_status_d;
  logic                    wait_load, wait_dec, wait_zero;
  logic                    gap_load, gap_dec, gap_zero;
  logic                    poll_hit, poll_last;

  apb_wait_timer #(.WIDTH(8)) u_wait_timer (
    .clk        (pclk),
    .rst        (sreset),
    .load_i     (wait_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (wait_dec),
    .zero_o     (wait_zero)
  );

  apb_wait_timer #(.WIDTH(4)) u_gap_timer (
    .clk        (pclk),
    .rst        (sreset),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

  assign poll_hit  = ((bus.prdata & mask_q) == (wdata_q & mask_q));
  assign poll_last = (({1'b0, poll_cnt_q} + 17'd1) == POLL_MAX);

  always_ff @(posedge pclk) begin
    if (sreset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_WRITE;
      wdata_q      <= '0;
      mask_q       <= '0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      poll_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      poll_cnt_q   <= poll_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    poll_cnt_d   = poll_cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    wait_load    = 1'b0;
    wait_dec     = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d       = (bus.cmd_op == OP_POLL)  ? OP_POLL  :
                       (bus.cmd_op == OP_WRITE) ? OP_WRITE : OP_READ;
          wdata_d    = bus.cmd_wdata;
          mask_d     = bus.cmd_mask;
          paddr_d    = bus.cmd_addr;
          pwrite_d   = (bus.cmd_op == OP_WRITE);
          pwdata_d   = (bus.cmd_op == OP_WRITE) ? bus.cmd_wdata : '0;
          poll_cnt_d = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        wait_load = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.pready) begin
          if (op_q != OP_WRITE) begin
            rsp_rdata_d = bus.prdata;
          end
          // Completion priority: slave error, plain access, poll match, poll exhaustion.
          if (bus.pslverr) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = RSP_SLVERR;
            state_d      = S_IDLE;
          end else if ((op_q != OP_POLL) || poll_hit) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = RSP_OK;
            state_d      = S_IDLE;
          end else if (poll_last) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = RSP_POLL_TO;
            state_d      = S_IDLE;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
            if (POLL_GAP == 0) begin
              state_d = S_SETUP;
            end else begin
              gap_load = 1'b1;
              state_d  = S_GAP;
            end
          end
        end else if (wait_zero) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_WAIT_TO;
          state_d      = S_IDLE;
        end else begin
          wait_dec = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_zero) begin
          state_d = S_SETUP;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.psel       = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.penable    = (state_q == S_ACCESS);
  assign bus.paddr      = paddr_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_status = rsp_status_q;

endmodule
